// File: rtl/lattice_step_ctrl.sv
// lattice_step_ctrl: sequencer for the lane-parallel binomial-lattice backward induction.
// It streams the leaf (expiry) beats, then walks levels N-1..0. For each level it issues
// beat indices and per-beat lane-valid masks. After every level it waits PIPE_LAT drain
// cycles so written-back values settle before the next level reads them.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start_i          begin a run; sampled only while idle
//   num_steps_i      tree depth N; latched (clamped to MAX_STEPS) when start is accepted
//   abort_i          synchronous cancel of a run in progress (beats and drain)
//   beat_ready_i     downstream accepts the current beat
//   busy_o           run in progress (load, step or drain)
//   done_o           one-cycle pulse; the level-0 result is in the node buffer
//   beat_valid_o     beat_idx_o/level_o/lane_valid_o are valid this cycle
//   beat_load_o      beat is a leaf-load beat
//   beat_first_o     first beat of the current level
//   beat_last_o      last beat of the current level
//   beat_idx_o       beat number within the level, 0-based
//   level_o          current lattice level (N for load, then N-1..0)
//   lane_valid_o     lanes producing real nodes this beat
// All outputs are registered. Beat payload outputs read 0 while beat_valid_o is low.
module lattice_step_ctrl #(
    parameter int unsigned LANES     = 32,
    parameter int unsigned MAX_STEPS = 1023,
    parameter int unsigned STEP_W    = 10,
    parameter int unsigned BEAT_W    = 6,
    parameter int unsigned PIPE_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [STEP_W-1:0] num_steps_i,
    input  logic              abort_i,
    input  logic              beat_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              beat_valid_o,
    output logic              beat_load_o,
    output logic              beat_first_o,
    output logic              beat_last_o,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic [STEP_W-1:0] level_o,
    output logic [LANES-1:0]  lane_valid_o
);

    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {StIdle, StLoad, StStep, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  level_q, level_d;
    logic [BEAT_W-1:0]  beat_idx_q, beat_idx_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               level_end;
    logic [BEAT_W-1:0]  last_idx_q, last_idx_d;

    logic              busy_d, done_d, beat_valid_d, beat_load_d, beat_first_d, beat_last_d;
    logic [BEAT_W-1:0] beat_idx_out_d;
    logic [STEP_W-1:0] level_out_d;
    logic [LANES-1:0]  lane_valid_d;

    // Load levels carry N+1 leaves; step levels read L+2 inputs to produce L+1 nodes.
    function automatic logic [BEAT_W-1:0] last_beat(input logic [STEP_W-1:0] lvl,
                                                    input logic is_load);
        int unsigned nodes;
        nodes = 32'(lvl) + (is_load ? 32'd0 : 32'd1);
        return BEAT_W'(nodes / LANES);
    endfunction

    // Only L+1 output nodes are real; the last beat may carry none (e.g. L=31, 32 lanes).
    function automatic logic [LANES-1:0] last_mask(input logic [STEP_W-1:0] lvl,
                                                   input logic is_load);
        int unsigned      last_i;
        int unsigned      cnt;
        logic [LANES-1:0] m;
        last_i = (32'(lvl) + (is_load ? 32'd0 : 32'd1)) / LANES;
        cnt    = 32'(lvl) + 32'd1 - last_i * LANES;
        for (int unsigned i = 0; i < LANES; i++) begin
            m[i] = (i < cnt);
        end
        return m;
    endfunction

    assign last_idx_q = last_beat(level_q, state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        beat_idx_d = beat_idx_q;
        drain_d    = drain_q;
        level_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StLoad;
                    level_d    = (32'(num_steps_i) > MAX_STEPS) ? STEP_W'(MAX_STEPS)
                                                                : num_steps_i;
                    beat_idx_d = '0;
                end
            end
            StLoad, StStep: begin
                // beat_valid is high in every load/step cycle, so ready alone completes a beat
                if (abort_i) begin
                    state_d = StIdle;
                end else if (beat_ready_i) begin
                    if (beat_idx_q == last_idx_q) begin
                        if (PIPE_LAT == 0) begin
                            level_end = 1'b1;
                        end else begin
                            state_d = StDrain;
                            drain_d = '0;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (drain_q == DRAIN_LAST) begin
                    level_end = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (level_end) begin
            if (level_q != '0) begin
                level_d    = level_q - 1'b1;
                beat_idx_d = '0;
                state_d    = StStep;
            end else begin
                state_d = StDone;
            end
        end
    end

    // Registered outputs are decoded from the next state so they line up with it.
    assign last_idx_d = last_beat(level_d, state_d == StLoad);

    always_comb begin
        busy_d         = (state_d == StLoad) || (state_d == StStep) || (state_d == StDrain);
        done_d         = (state_d == StDone);
        beat_valid_d   = (state_d == StLoad) || (state_d == StStep);
        beat_load_d    = 1'b0;
        beat_first_d   = 1'b0;
        beat_last_d    = 1'b0;
        beat_idx_out_d = '0;
        level_out_d    = '0;
        lane_valid_d   = '0;
        if (beat_valid_d) begin
            beat_load_d    = (state_d == StLoad);
            beat_first_d   = (beat_idx_d == '0);
            beat_last_d    = (beat_idx_d == last_idx_d);
            beat_idx_out_d = beat_idx_d;
            level_out_d    = level_d;
            lane_valid_d   = beat_last_d ? last_mask(level_d, state_d == StLoad) : '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            level_q      <= '0;
            beat_idx_q   <= '0;
            drain_q      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            beat_valid_o <= 1'b0;
            beat_load_o  <= 1'b0;
            beat_first_o <= 1'b0;
            beat_last_o  <= 1'b0;
            beat_idx_o   <= '0;
            level_o      <= '0;
            lane_valid_o <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            beat_idx_q   <= beat_idx_d;
            drain_q      <= drain_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            beat_valid_o <= beat_valid_d;
            beat_load_o  <= beat_load_d;
            beat_first_o <= beat_first_d;
            beat_last_o  <= beat_last_d;
            beat_idx_o   <= beat_idx_out_d;
            level_o      <= level_out_d;
            lane_valid_o <= lane_valid_d;
        end
    end

endmodule

// File: tb/tb_lattice_step_ctrl.sv
// Directed bench for lattice_step_ctrl (PIPE_LAT=2, STEP_W=11 so depths above MAX_STEPS fit).
module tb_lattice_step_ctrl;

    localparam int unsigned LANES     = 32;
    localparam int unsigned MAX_STEPS = 1023;
    localparam int unsigned STEP_W    = 11;
    localparam int unsigned BEAT_W    = 6;
    localparam int unsigned PIPE_LAT  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [STEP_W-1:0] num_steps_i = '0;
    logic              abort_i = 1'b0;
    logic              beat_ready_i = 1'b1;
    logic              busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o;
    logic [BEAT_W-1:0] beat_idx_o;
    logic [STEP_W-1:0] level_o;
    logic [LANES-1:0]  lane_valid_o;

    int total = 0;
    int bad   = 0;

    lattice_step_ctrl #(
        .LANES    (LANES),
        .MAX_STEPS(MAX_STEPS),
        .STEP_W   (STEP_W),
        .BEAT_W   (BEAT_W),
        .PIPE_LAT (PIPE_LAT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .num_steps_i (num_steps_i),
        .abort_i     (abort_i),
        .beat_ready_i(beat_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .beat_valid_o(beat_valid_o),
        .beat_load_o (beat_load_o),
        .beat_first_o(beat_first_o),
        .beat_last_o (beat_last_o),
        .beat_idx_o  (beat_idx_o),
        .level_o     (level_o),
        .lane_valid_o(lane_valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o, beat_idx_o,
             level_o, lane_valid_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b level=%0d mask=%h, want 0",
                     busy_o, done_o, beat_valid_o, level_o, lane_valid_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({busy_o, done_o, beat_valid_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got busy/done/valid=%b want 000",
                     {busy_o, done_o, beat_valid_o});
        end
    endtask

    // N=2 run: load at cyc1, levels 1 and 0 at cyc4 and cyc7, done at cyc10.
    task automatic run_n2(input string tag);
        logic              bv;
        logic [5:0]        fl_exp;
        logic [STEP_W-1:0] l_exp;
        logic [LANES-1:0]  m_exp;
        beat_ready_i = 1'b1;
        num_steps_i  = 2;
        start_i      = 1'b1;
        tick();
        start_i     = 1'b0;
        num_steps_i = 7;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            bv     = (cyc == 1) || (cyc == 4) || (cyc == 7);
            fl_exp = {(cyc <= 9), (cyc == 10), bv, (cyc == 1), bv, bv};
            l_exp  = (cyc == 1) ? 2 : ((cyc == 4) ? 1 : 0);
            m_exp  = (cyc == 1) ? 32'h7 : ((cyc == 4) ? 32'h3 : 32'h1);
            total++;
            if ({busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o} !== fl_exp
                || (bv && (level_o !== l_exp || lane_valid_o !== m_exp || beat_idx_o !== 0)))
            begin
                bad++;
                $display("FAIL %s cyc%0d: flags=%b want %b level=%0d want %0d mask=%h want %h idx=%0d",
                         tag, cyc, {busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o,
                         beat_last_o}, fl_exp, level_o, l_exp, lane_valid_o, m_exp, beat_idx_o);
            end
            tick();
        end
    endtask

    task automatic test_basic_n2();
        run_n2("basic_n2");
    endtask

    task automatic test_n32_masks();
        logic [51:0] beats[$];
        logic [51:0] exp_b[6];
        int          idx_chk[6];
        bit          seen_done;
        beat_ready_i = 1'b1;
        num_steps_i  = 32;
        start_i      = 1'b1;
        tick();
        start_i   = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (beat_valid_o) begin
                beats.push_back({beat_load_o, beat_first_o, beat_last_o, beat_idx_o, level_o,
                                 lane_valid_o});
            end
            if (done_o) begin
                seen_done = 1'b1;
                break;
            end
            tick();
        end
        tick();
        total++;
        if (!seen_done || beats.size() != 35) begin
            bad++;
            $display("FAIL n32_count: done=%0d beats=%0d want done=1 beats=35", seen_done,
                     beats.size());
        end
        exp_b[0] = {3'b110, 6'd0, 11'd32, 32'hFFFF_FFFF};
        exp_b[1] = {3'b101, 6'd1, 11'd32, 32'h0000_0001};
        exp_b[2] = {3'b010, 6'd0, 11'd31, 32'hFFFF_FFFF};
        exp_b[3] = {3'b001, 6'd1, 11'd31, 32'h0000_0000};
        exp_b[4] = {3'b011, 6'd0, 11'd30, 32'h7FFF_FFFF};
        exp_b[5] = {3'b011, 6'd0, 11'd0,  32'h0000_0001};
        idx_chk  = '{0, 1, 2, 3, 4, 34};
        for (int k = 0; k < 6; k++) begin
            if (beats.size() > idx_chk[k]) begin
                total++;
                if (beats[idx_chk[k]] !== exp_b[k]) begin
                    bad++;
                    $display("FAIL n32_beat%0d: got %h want %h", idx_chk[k], beats[idx_chk[k]],
                             exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]  pat;
        logic [55:0] prev_snap, snap;
        bit          prev_stall;
        int          acc[40];
        int          acc_load, stalls, done_cyc;
        pat        = 4'b1001;
        prev_stall = 1'b0;
        prev_snap  = '0;
        acc_load   = 0;
        stalls     = 0;
        done_cyc   = 0;
        for (int l = 0; l < 40; l++) acc[l] = 0;
        beat_ready_i = 1'b1;
        num_steps_i  = 40;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            beat_ready_i = pat[(cyc - 1) % 4];
            snap = {beat_valid_o, beat_load_o, beat_first_o, beat_last_o, beat_idx_o, level_o,
                    lane_valid_o, 2'b00};
            if (prev_stall) begin
                total++;
                if (snap !== prev_snap) begin
                    bad++;
                    $display("FAIL stall_hold cyc%0d: got %h want %h", cyc, snap, prev_snap);
                end
            end
            if (beat_valid_o) begin
                if (beat_ready_i) begin
                    if (beat_load_o) acc_load++;
                    else if (level_o < 40) acc[level_o]++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = beat_valid_o && !beat_ready_i;
            prev_snap  = snap;
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        beat_ready_i = 1'b1;
        tick();
        // Unstalled N=40 with PIPE_LAT=2: 51 beats + 41 drains * 2 = 133 busy cycles.
        total++;
        if (done_cyc != 134 + stalls) begin
            bad++;
            $display("FAIL stall_done: done at cyc%0d want cyc%0d (stalls=%0d)", done_cyc,
                     134 + stalls, stalls);
        end
        total++;
        if (acc_load != 2) begin
            bad++;
            $display("FAIL stall_load_beats: got %0d want 2", acc_load);
        end
        for (int l = 0; l < 40; l++) begin
            total++;
            if (acc[l] != (l + 2 + 31) / 32) begin
                bad++;
                $display("FAIL stall_level%0d_beats: got %0d want %0d", l, acc[l],
                         (l + 2 + 31) / 32);
            end
        end
    endtask

    task automatic test_n0();
        beat_ready_i = 1'b1;
        num_steps_i  = 0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        total++;
        if ({busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o} !== 6'b101111
            || level_o !== 0 || lane_valid_o !== 32'h1 || beat_idx_o !== 0) begin
            bad++;
            $display("FAIL n0_load: flags=%b want 101111 level=%0d mask=%h want 0/1",
                     {busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o},
                     level_o, lane_valid_o);
        end
        for (int cyc = 2; cyc <= 5; cyc++) begin
            tick();
            total++;
            if ({busy_o, done_o, beat_valid_o} !==
                ((cyc == 4) ? 3'b010 : ((cyc == 5) ? 3'b000 : 3'b100))) begin
                bad++;
                $display("FAIL n0_cyc%0d: busy/done/valid=%b want %b", cyc,
                         {busy_o, done_o, beat_valid_o},
                         (cyc == 4) ? 3'b010 : ((cyc == 5) ? 3'b000 : 3'b100));
            end
        end
    endtask

    task automatic test_abort();
        bit found, seen_done;
        found        = 1'b0;
        seen_done    = 1'b0;
        beat_ready_i = 1'b1;
        num_steps_i  = 8;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (beat_valid_o && !beat_load_o && level_o == 5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_reach_l5: level 5 beat not seen, want seen");
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        total++;
        if ({busy_o, done_o, beat_valid_o} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle: busy/done/valid=%b want 000",
                     {busy_o, done_o, beat_valid_o});
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done_o || busy_o) seen_done = 1'b1;
            tick();
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL abort_no_done: done/busy seen after abort, want none");
        end
        run_n2("abort_restart");
    endtask

    task automatic test_rst_drain();
        beat_ready_i = 1'b1;
        num_steps_i  = 2;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        total++;
        if ({busy_o, beat_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL rst_drain_pre: busy/valid=%b want 10", {busy_o, beat_valid_o});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_o, done_o, beat_valid_o, beat_load_o, beat_first_o, beat_last_o, beat_idx_o,
             level_o, lane_valid_o} !== '0) begin
            bad++;
            $display("FAIL rst_drain_async: busy=%b done=%b valid=%b level=%0d, want all 0",
                     busy_o, done_o, beat_valid_o, level_o);
        end
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) tick();
        total++;
        if ({busy_o, done_o, beat_valid_o} !== 3'b000) begin
            bad++;
            $display("FAIL rst_drain_after: busy/done/valid=%b want 000",
                     {busy_o, done_o, beat_valid_o});
        end
    endtask

    task automatic test_clamp();
        beat_ready_i = 1'b1;
        num_steps_i  = 2000;
        start_i      = 1'b1;
        tick();
        start_i     = 1'b0;
        num_steps_i = 5;
        total++;
        if (level_o !== 1023 || {beat_valid_o, beat_load_o, beat_first_o, beat_last_o} !== 4'b1110
            || beat_idx_o !== 0 || lane_valid_o !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL clamp_level: level=%0d want 1023 flags=%b want 1110 idx=%0d mask=%h",
                     level_o, {beat_valid_o, beat_load_o, beat_first_o, beat_last_o}, beat_idx_o,
                     lane_valid_o);
        end
        tick();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++;
        if (level_o !== 1023 || beat_idx_o !== 3 || !beat_load_o || !busy_o) begin
            bad++;
            $display("FAIL start_ignored: level=%0d idx=%0d load=%b want 1023/3/1", level_o,
                     beat_idx_o, beat_load_o);
        end
        for (int cyc = 5; cyc <= 32; cyc++) tick();
        total++;
        if (beat_idx_o !== 31 || !beat_last_o || lane_valid_o !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL clamp_last_load: idx=%0d last=%b mask=%h want 31/1/ffffffff",
                     beat_idx_o, beat_last_o, lane_valid_o);
        end
        tick();
        tick();
        tick();
        total++;
        if (level_o !== 1022 || beat_idx_o !== 0 || beat_load_o || !beat_first_o
            || beat_last_o || lane_valid_o !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL clamp_step1022: level=%0d idx=%0d load=%b first=%b last=%b mask=%h",
                     level_o, beat_idx_o, beat_load_o, beat_first_o, beat_last_o,
                     lane_valid_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        total++;
        if ({busy_o, done_o, beat_valid_o} !== 3'b000) begin
            bad++;
            $display("FAIL clamp_abort: busy/done/valid=%b want 000",
                     {busy_o, done_o, beat_valid_o});
        end
    endtask

    initial begin
        test_reset();
        test_basic_n2();
        test_n32_masks();
        test_stall();
        test_n0();
        test_abort();
        test_rst_drain();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
